// File: rtl/vga_sync_decoder_pkg.sv
// Shared 640x480@60 timing constants and decoder FSM encoding, common to the
// sync generator and the sync decoder.
package vga_sync_decoder_pkg;
   localparam int H_TOTAL      = 800;
   localparam int H_VIS        = 640;
   localparam int H_SYNC_START = 656;
   localparam int V_TOTAL      = 525;
   localparam int V_VIS        = 480;
   localparam int V_SYNC_START = 490;
   localparam int LEN_MAX      = 1023;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } sync_state_e;
endpackage

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from an hsync/vsync pair and verifies that the
// stream has 640x480@60 timing before asserting locked.
module vga_sync_decoder
   import vga_sync_decoder_pkg::*;
#(
   parameter int P_H_TOTAL      = H_TOTAL,
   parameter int P_H_VIS        = H_VIS,
   parameter int P_H_SYNC_START = H_SYNC_START,
   parameter int P_V_TOTAL      = V_TOTAL,
   parameter int P_V_VIS        = V_VIS,
   parameter int P_V_SYNC_START = V_SYNC_START,
   parameter int P_LEN_MAX      = LEN_MAX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       de,
   output logic       frame_start,
   output logic       locked,
   output logic       err
);

   localparam logic [9:0] HT      = 10'(P_H_TOTAL);
   localparam logic [9:0] HT_LAST = 10'(P_H_TOTAL - 1);
   localparam logic [9:0] HVIS    = 10'(P_H_VIS);
   localparam logic [9:0] HSS     = 10'(P_H_SYNC_START);
   localparam logic [9:0] VT      = 10'(P_V_TOTAL);
   localparam logic [9:0] VT_LAST = 10'(P_V_TOTAL - 1);
   localparam logic [9:0] VVIS    = 10'(P_V_VIS);
   localparam logic [9:0] VSS     = 10'(P_V_SYNC_START);
   localparam logic [9:0] LMAX    = 10'(P_LEN_MAX);
   localparam logic [9:0] LMAX_M1 = 10'(P_LEN_MAX - 1);

   sync_state_e state_q, state_d;
   logic        hprev_q, vprev_q;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [9:0]  len_q, len_d, lines_q, lines_d, lines_cnt;
   logic        err_q, err_d, fs_q, fs_d;
   logic        h_edge, v_edge, x_wrap, len_bad, lines_bad, len_hit;

   // Datapath: position counters plus the line-length / line-count monitors.
   always_comb begin
      h_edge    = pix_en & hprev_q & ~hsync;
      v_edge    = pix_en & vprev_q & ~vsync;
      x_wrap    = ~h_edge & (x_q == HT_LAST);
      // A coincident hsync edge belongs to the frame being closed.
      lines_cnt = (h_edge && lines_q != 10'h3FF) ? lines_q + 10'd1 : lines_q;
      len_bad   = h_edge & (len_q != HT);
      lines_bad = v_edge & (lines_cnt != VT);
      len_hit   = pix_en & ~h_edge & (len_q == LMAX_M1);

      x_d     = x_q;
      y_d     = y_q;
      len_d   = len_q;
      lines_d = lines_q;
      if (pix_en) begin
         x_d = h_edge ? HSS : (x_wrap ? 10'd0 : x_q + 10'd1);
         if (v_edge)
            y_d = VSS;
         else if (x_wrap)
            y_d = (y_q == VT_LAST) ? 10'd0 : y_q + 10'd1;
         len_d   = h_edge ? 10'd1 : ((len_q == LMAX) ? len_q : len_q + 10'd1);
         lines_d = v_edge ? 10'd0 : lines_cnt;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_SEARCH: if (v_edge) state_d = ST_TRACK;
         ST_TRACK: begin
            if (len_bad)
               state_d = ST_SEARCH;
            else if (v_edge)
               state_d = lines_bad ? ST_SEARCH : ST_LOCKED;
         end
         ST_LOCKED: begin
            if (len_bad || lines_bad || len_hit) begin
               state_d = ST_SEARCH;
               err_d   = 1'b1;
            end
         end
         default: state_d = ST_SEARCH;
      endcase
      fs_d = pix_en & (state_d == ST_LOCKED) & (x_d == 10'd0) & (y_d == 10'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_SEARCH;
         hprev_q <= 1'b1;
         vprev_q <= 1'b1;
         x_q     <= '0;
         y_q     <= '0;
         len_q   <= '0;
         lines_q <= '0;
         err_q   <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         len_q   <= len_d;
         lines_q <= lines_d;
         err_q   <= err_d;
         fs_q    <= fs_d;
         if (pix_en) begin
            hprev_q <= hsync;
            vprev_q <= vsync;
         end
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign locked      = (state_q == ST_LOCKED);
   assign de          = locked & (x_q < HVIS) & (y_q < VVIS);
   assign frame_start = fs_q;
   assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboarded bench: a sync generator drives the decoder with reduced
// timing so many frames fit; a reference model predicts every strobe.
module tb_vga_sync_decoder;

   localparam int HT = 24, HV = 16, HSS = 18, HSW = 3;
   localparam int VT = 14, VV = 10, VSS = 11, VSW = 2;
   localparam int LM = 60;
   localparam int FRAME = HT * VT;

   logic       clk = 1'b0, rst = 1'b1, pix_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
   logic [9:0] x, y;
   logic       de, frame_start, locked, err;

   vga_sync_decoder #(
      .P_H_TOTAL(HT), .P_H_VIS(HV), .P_H_SYNC_START(HSS),
      .P_V_TOTAL(VT), .P_V_VIS(VV), .P_V_SYNC_START(VSS), .P_LEN_MAX(LM)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
      .x(x), .y(y), .de(de), .frame_start(frame_start), .locked(locked), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x, y, de, fs, lk, err;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_fail = 0, err_seen = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: spec rules evaluated with plain integers.
   int m_hp, m_vp, m_hn, m_ln, m_st, m_x, m_y;

   task automatic model_reset();
      m_hp = 1; m_vp = 1; m_hn = 0; m_ln = 0; m_st = 0; m_x = 0; m_y = 0;
   endtask

   task automatic model_step(input int h, input int v);
      int he, ve, lc, lenbad, reach, e, wrap, lk;
      exp_t ex;
      he     = (m_hp == 1 && h == 0) ? 1 : 0;
      ve     = (m_vp == 1 && v == 0) ? 1 : 0;
      lc     = m_ln + he;
      lenbad = (he == 1 && m_hn != HT) ? 1 : 0;
      reach  = (he == 0 && m_hn + 1 == LM) ? 1 : 0;
      e      = 0;
      if (m_st == 0) begin
         if (ve == 1) m_st = 1;
      end else if (m_st == 1) begin
         if (lenbad == 1) m_st = 0;
         else if (ve == 1) m_st = (lc == VT) ? 2 : 0;
      end else begin
         if (lenbad == 1 || (ve == 1 && lc != VT) || reach == 1) begin
            e = 1; m_st = 0;
         end
      end
      wrap = (he == 0 && m_x == HT - 1) ? 1 : 0;
      m_x  = (he == 1) ? HSS : (m_x + 1) % HT;
      if (ve == 1) m_y = VSS;
      else if (wrap == 1) m_y = (m_y + 1) % VT;
      m_hn = (he == 1) ? 1 : m_hn + 1;
      m_ln = (ve == 1) ? 0 : lc;
      m_hp = h; m_vp = v;
      lk     = (m_st == 2) ? 1 : 0;
      ex.x   = m_x;
      ex.y   = m_y;
      ex.lk  = lk;
      ex.de  = (lk == 1 && m_x < HV && m_y < VV) ? 1 : 0;
      ex.fs  = (lk == 1 && m_x == 0 && m_y == 0) ? 1 : 0;
      ex.err = e;
      q.push_back(ex);
   endtask

   // Monitor: strobe cycles are checked against the scoreboard; other cycles
   // must not carry a pulse.
   always begin
      @(posedge clk);
      if (pix_en && !rst) begin
         exp_t ex;
         #1;
         if (err) err_seen++;
         if (q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
         end else begin
            ex = q.pop_front();
            chk("x", int'(x), ex.x);
            chk("y", int'(y), ex.y);
            chk("de", int'(de), ex.de);
            chk("frame_start", int'(frame_start), ex.fs);
            chk("locked", int'(locked), ex.lk);
            chk("err", int'(err), ex.err);
         end
      end else begin
         #1;
         if (!rst) begin
            if (err) err_seen++;
            chk("err_idle", int'(err), 0);
            chk("frame_start_idle", int'(frame_start), 0);
         end
      end
   end

   // Generator: 640x480-style raster, vsync edges coincide with hsync edges.
   int gx, gy;
   bit short_line = 0, short_frame = 0;

   function automatic logic hs_f();
      return !(gx >= HSS && gx < HSS + HSW);
   endfunction

   function automatic logic vs_f();
      int vl;
      vl = (gx >= HSS) ? gy : ((gy == 0) ? VT - 1 : gy - 1);
      return !(vl >= VSS && vl < VSS + VSW);
   endfunction

   task automatic strobe(input logic h, input logic v);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      hsync  = h;
      vsync  = v;
      pix_en = 1'b1;
      model_step(int'(h), int'(v));
      @(negedge clk);
      pix_en = 1'b0;
   endtask

   task automatic advance();
      int ll, fl;
      ll = short_line ? HT - 1 : HT;
      if (gx >= ll - 1) begin
         gx = 0;
         short_line = 0;
         fl = short_frame ? VT - 1 : VT;
         if (gy >= fl - 1) begin
            gy = 0;
            short_frame = 0;
         end else gy++;
      end else gx++;
   endtask

   task automatic gen(input int n);
      for (int i = 0; i < n; i++) begin
         strobe(hs_f(), vs_f());
         advance();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_x"}, int'(x), 0);
      chk({tag, "_y"}, int'(y), 0);
      chk({tag, "_de"}, int'(de), 0);
      chk({tag, "_frame_start"}, int'(frame_start), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_err"}, int'(err), 0);
   endtask

   initial begin
      int e0;
      bit hit;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      gx = $urandom_range(0, HT - 1);
      gy = $urandom_range(0, VT - 1);

      // Acquire lock from an arbitrary raster phase.
      gen(FRAME * 3);
      chk("lock_acquired", int'(locked), 1);

      // One short line while locked.
      e0 = err_seen;
      gen($urandom_range(FRAME / 4, FRAME / 2));
      short_line = 1;
      gen(HT * 2);
      chk("short_line_unlocked", int'(locked), 0);
      gen(FRAME * 4);
      chk("short_line_err_count", err_seen - e0, 1);
      chk("short_line_relock", int'(locked), 1);

      // hsync held inactive past the length limit.
      e0 = err_seen;
      for (int i = 0; i < LM + 40; i++) strobe(1'b1, vs_f());
      chk("hold_unlocked", int'(locked), 0);
      gen(FRAME * 4);
      chk("hold_err_count", err_seen - e0, 1);
      chk("hold_relock", int'(locked), 1);

      // One frame a line short.
      e0 = err_seen;
      short_frame = 1;
      gen(FRAME * 4);
      chk("short_frame_err_count", err_seen - e0, 1);
      chk("short_frame_relock", int'(locked), 1);

      // Asynchronous reset mid-frame, then resync.
      hit = 0;
      for (int i = 0; i < FRAME * 2 && !hit; i++) begin
         if (gx == 10 && gy == 5) hit = 1;
         else begin
            strobe(hs_f(), vs_f());
            advance();
         end
      end
      chk("reset_point_reached", int'(hit), 1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midframe_reset");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      e0 = err_seen;
      gen(FRAME * 4);
      chk("post_reset_err_count", err_seen - e0, 0);
      chk("post_reset_relock", int'(locked), 1);

      // Random disturbances.
      for (int k = 0; k < 3; k++) begin
         case ($urandom_range(0, 2))
            0: short_line = 1;
            1: short_frame = 1;
            default: for (int i = 0; i < LM + $urandom_range(0, 20); i++) strobe(1'b1, vs_f());
         endcase
         gen(FRAME * 4 + $urandom_range(0, FRAME));
         chk("random_relock", int'(locked), 1);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
